wb_stage_mt: RTL
================

# wb_stage_mt

Parametrised writeback stage for the multithreaded RISC-V core. It sits between the memory stage and the register file. It aligns and extends load data, selects the load or ALU result, and suppresses writes to x0. It decouples from register-file back-pressure through a two-entry skid buffer and keeps one retired-instruction counter per hart.

## Interface
- XLEN, 32, datapath width (32 or 64)
- NUM_HARTS, 4, hardware thread count (≥2); HART_W = $clog2(NUM_HARTS) derived localparam
- REG_AW, 5, register address width
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream result valid
- in_ready  out  1  stage can accept
- in_wdata  in  XLEN  ALU/CSR result
- in_ram_out  in  XLEN  raw memory read word
- in_waddr  in  REG_AW  destination register
- in_regwrite  in  1  instruction writes a register
- in_memtoreg  in  1  select load data
- in_ldfunct3  in  3  load size/sign (LB=0, LH=1, LW=2, LBU=4, LHU=5)
- in_addr_lo  in  2  low address bits of load
- in_hart  in  HART_W  issuing hart ID
- rf_valid  out  1  writeback valid
- rf_ready  in  1  register file accepts
- rf_wdata  out  XLEN  write data
- rf_waddr  out  REG_AW  write address
- rf_we  out  1  write enable (0 for x0 or no regwrite)
- rf_hart  out  HART_W  target hart register bank
- instret_sel  in  HART_W  counter read select (WB_INSTRET_EN only)
- instret_val  out  64  selected hart's retire count (WB_INSTRET_EN only)

## Operation
- Load alignment: byte = ram_out >> (8·addr_lo); half = ram_out >> (16·addr_lo[1]); addr_lo[0] is ignored for halves and addr_lo is ignored for words. LB/LH sign-extend to XLEN. LBU/LHU zero-extend. LW on XLEN=64 sign-extends bit 31. funct3 values 3, 6, 7 are treated as LW.
- Result = in_memtoreg ? aligned load : in_wdata.
- Captured rf_we = in_regwrite & (in_waddr != 0). Entries with rf_we=0 still flow through so that retirement is counted.
- Skid buffer states: EMPTY, ONE (output register full), TWO (output and skid full).
  - EMPTY + accept → ONE.
  - ONE + accept without drain → TWO.
  - ONE + drain without accept → EMPTY.
  - ONE + accept with drain → ONE (new entry takes the output slot).
  - TWO + drain → ONE (skid moves to output).
- in_ready = (state != TWO); it is a registered-state function with no combinational path from rf_ready.
- Order is strict FIFO across all harts; there is no reordering.
- Retire counter: a hart's counter increments by 1 on each rf_valid & rf_ready for that rf_hart. It is 64-bit and wraps from all-ones to 0. in_hart ≥ NUM_HARTS (non-power-of-2 configs) passes through uncounted.

## Timing
- Reset values: rf_valid=0, rf_wdata=0, rf_waddr=0, rf_we=0, rf_hart=0, state=EMPTY, in_ready=1, all counters 0.
- Latency: 1 cycle from acceptance to rf_valid when the buffer is empty. Throughput is 1 per cycle while rf_ready=1.
- rf_* outputs are held stable while rf_valid & !rf_ready.
- instret_val is combinational from instret_sel. If a read coincides with an increment of the same hart, it returns the pre-increment value. The new value is visible the next cycle.
- rst_n low mid-operation clears buffered entries immediately and asynchronously; they are lost, not replayed. Counters clear. Release is synchronised externally.

## Configuration
- WB_INSTRET_EN defined: per-hart 64-bit counters, instret_sel and instret_val are present.
- WB_INSTRET_EN undefined: no counters are built, and instret_sel and instret_val are omitted from the port list. All other behaviour is identical.

## Structure
- wb_pkg: load funct3 enum (LB/LH/LW/LBU/LHU), skid state enum (EMPTY/ONE/TWO), writeback entry struct {wdata, waddr, we, hart} parametrised by default widths.
- One sub-module: wb_load_align, a combinational block mapping (ram_out, funct3, addr_lo) to the aligned XLEN value.

## Test plan
- Reset then single LB: ram_out=0x80FF_7F01, addr_lo=3, funct3=LB → rf_wdata=0xFFFF_FF80 one cycle later. Same with LBU → 0x0000_0080.
- LH with addr_lo=2 on 0x8001_1234 → 0xFFFF_8001. LHU → 0x0000_8001. Invalid funct3=7 → 0x8001_1234.
- Write to x0 with regwrite=1, waddr=0 → rf_valid=1 and rf_we=0. The counter for that hart still increments.
- Back-pressure: hold rf_ready=0 and push 3 entries → the first two are accepted and in_ready drops after the second. Release → all three are delivered in order with no duplicates.
- Interleaved harts 0,1,2,3,0 with rf_ready=1 → instret for hart0=2, others=1. A same-cycle read of a hart being incremented returns the old value.
- Assert rst_n mid-burst with two entries buffered → rf_valid=0 immediately, in_ready=1, counters=0, and no stale entry appears after release.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the writeback stage: load funct3 codes, skid-buffer states
// and a default-width writeback entry.
package wb_pkg;

    localparam int DEF_XLEN   = 32;
    localparam int DEF_REG_AW = 5;
    localparam int DEF_HART_W = 2;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        LBU = 3'd4,
        LHU = 3'd5
    } load_f3_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

    typedef struct packed {
        logic [DEF_XLEN-1:0]   wdata;
        logic [DEF_REG_AW-1:0] waddr;
        logic                  we;
        logic [DEF_HART_W-1:0] hart;
    } wb_entry_t;

endpackage

// File: rtl/wb_load_align.sv
// Combinational load aligner: picks the byte/half/word addressed by addr_lo
// and sign- or zero-extends it to XLEN.
module wb_load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] ram_out,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] aligned
);

    logic [31:0]     word_v;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic [XLEN-1:0] word_ext;

    assign word_v = ram_out[31:0];
    assign byte_v = word_v[{addr_lo, 3'b000} +: 8];
    assign half_v = word_v[{addr_lo[1], 4'b0000} +: 16];

    // Word loads sign-extend bit 31 only when the datapath is wider than 32.
    generate
        if (XLEN == 32) begin : g_word32
            assign word_ext = word_v;
        end else begin : g_word_wide
            assign word_ext = {{(XLEN-32){word_v[31]}}, word_v};
        end
    endgenerate

    always_comb begin
        aligned = word_ext;
        case (funct3)
            LB:      aligned = {{(XLEN-8){byte_v[7]}}, byte_v};
            LH:      aligned = {{(XLEN-16){half_v[15]}}, half_v};
            LBU:     aligned = {{(XLEN-8){1'b0}}, byte_v};
            LHU:     aligned = {{(XLEN-16){1'b0}}, half_v};
            default: aligned = word_ext;
        endcase
    end

endmodule

// File: rtl/wb_stage_mt.sv
// Multithreaded writeback stage with a two-entry skid buffer toward the register
// file; per-hart retire counters are built only when WB_INSTRET_EN is defined.
module wb_stage_mt
    import wb_pkg::*;
#(
    parameter int  XLEN      = 32,
    parameter int  NUM_HARTS = 4,
    parameter int  REG_AW    = 5,
    localparam int HART_W    = $clog2(NUM_HARTS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic [XLEN-1:0]   in_ram_out,
    input  logic [REG_AW-1:0] in_waddr,
    input  logic              in_regwrite,
    input  logic              in_memtoreg,
    input  logic [2:0]        in_ldfunct3,
    input  logic [1:0]        in_addr_lo,
    input  logic [HART_W-1:0] in_hart,
    output logic              rf_valid,
    input  logic              rf_ready,
    output logic [XLEN-1:0]   rf_wdata,
    output logic [REG_AW-1:0] rf_waddr,
    output logic              rf_we,
    output logic [HART_W-1:0] rf_hart
`ifdef WB_INSTRET_EN
    ,
    input  logic [HART_W-1:0] instret_sel,
    output logic [63:0]       instret_val
`endif
);

    typedef struct packed {
        logic [XLEN-1:0]   wdata;
        logic [REG_AW-1:0] waddr;
        logic              we;
        logic [HART_W-1:0] hart;
    } entry_t;

    skid_state_e state, state_next;
    entry_t      out_q, skid_q, new_entry;
    logic [XLEN-1:0] load_data;
    logic        accept, drain;
    logic        load_out, load_skid, out_from_skid;

    wb_load_align #(.XLEN(XLEN)) u_align (
        .ram_out (in_ram_out),
        .funct3  (in_ldfunct3),
        .addr_lo (in_addr_lo),
        .aligned (load_data)
    );

    assign new_entry.wdata = in_memtoreg ? load_data : in_wdata;
    assign new_entry.waddr = in_waddr;
    assign new_entry.we    = in_regwrite & (in_waddr != '0);
    assign new_entry.hart  = in_hart;

    // Both handshake outputs depend only on registered state, never on rf_ready.
    assign in_ready = (state != TWO);
    assign rf_valid = (state != EMPTY);
    assign accept   = in_valid & in_ready;
    assign drain    = rf_valid & rf_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_next = ONE;
                    load_out   = 1'b1;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    state_next = TWO;
                    load_skid  = 1'b1;
                end else if (drain) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                if (drain) begin
                    state_next    = ONE;
                    out_from_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_out) begin
                out_q <= new_entry;
            end else if (out_from_skid) begin
                out_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= new_entry;
            end
        end
    end

    assign rf_wdata = out_q.wdata;
    assign rf_waddr = out_q.waddr;
    assign rf_we    = out_q.we;
    assign rf_hart  = out_q.hart;

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q [NUM_HARTS];

    // Out-of-range hart IDs (non-power-of-two configs) retire uncounted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_HARTS; i++) begin
                instret_q[i] <= '0;
            end
        end else if (drain && (int'(out_q.hart) < NUM_HARTS)) begin
            instret_q[out_q.hart] <= instret_q[out_q.hart] + 64'd1;
        end
    end

    assign instret_val = (int'(instret_sel) < NUM_HARTS) ? instret_q[instret_sel] : '0;
`endif

endmodule
